// File: rtl/cpu_pkg.sv
// cpu_pkg: shared CPU datapath widths, reset PC and fetch FSM encodings.
// Imported by instr_fetch_unit and fetch_pc_reg.
package cpu_pkg;

    localparam int          DEF_ADDR_W   = 16;
    localparam int          DEF_DATA_W   = 16;
    localparam int unsigned DEF_RESET_PC = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter with async reset; load beats increment beats hold.
// Ports: clk, reset, load/load_addr (redirect), inc (advance by one), pc.
module fetch_pc_reg
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int unsigned RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] pc_q;

    // Increment wraps modulo 2^ADDR_W with no overflow flag.
    always_comb begin
        pc_d = pc_q;
        if (load) begin
            pc_d = load_addr;
        end else if (inc) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetch FSM driving BRAM port A, instruction register and
// valid/ready handshake to the decoder; execute may redirect the PC.
// Ports: clk, reset, stall, redirect_valid/addr, mem_en/addr/rdata,
// instr, instr_pc, instr_valid, instr_ready.
// Build option FETCH_COUNT_EN adds fetch_count (completed handshakes).
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = DEF_ADDR_W,
    parameter int          DATA_W   = DEF_DATA_W,
    parameter int unsigned RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready
`ifdef FETCH_COUNT_EN
    ,
    output logic [31:0]       fetch_count
`endif
);

    fetch_state_e      state_d, state_q;
    logic [DATA_W-1:0] instr_d, instr_q;
    logic [ADDR_W-1:0] instr_pc_d, instr_pc_q;
    logic              valid_d, valid_q;
    logic [ADDR_W-1:0] pc;
    logic              pc_load;
    logic              pc_inc;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .reset     (reset),
        .load      (pc_load),
        .load_addr (redirect_addr),
        .inc       (pc_inc),
        .pc        (pc)
    );

    assign mem_addr = pc;
    assign mem_en   = (state_q == S_ISSUE) && !stall && !redirect_valid;

    // Redirect overrides every non-idle state; a read still in flight
    // during S_WAIT is dropped by simply not capturing mem_rdata.
    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        pc_load    = 1'b0;
        pc_inc     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                end else if (!stall) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    state_d = S_ISSUE;
                end else begin
                    instr_d    = mem_rdata;
                    instr_pc_d = pc;
                    pc_inc     = 1'b1;
                    valid_d    = 1'b1;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_load = 1'b1;
                    valid_d = 1'b0;
                    state_d = S_ISSUE;
                end else if (instr_ready) begin
                    valid_d = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
        end
    end

    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = valid_q;

`ifdef FETCH_COUNT_EN
    logic [31:0] count_d, count_q;

    // A handshake still counts when a redirect lands in the same cycle.
    always_comb begin
        count_d = count_q;
        if (valid_q && instr_ready) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and randomized checks of instr_fetch_unit
// against a transaction-level model of the fetch rules.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [15:0] mem_rdata = '0;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .mem_en         (mem_en),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] bram_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h1234;
    endfunction

    // Synchronous-read BRAM: data appears the cycle after mem_en.
    always @(posedge clk) begin
        if (mem_en) begin
            mem_rdata <= bram_word(mem_addr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Model: an output slot, one possible read in flight, and a PC.
    int          m_pc;
    bit          m_booted;
    bit          m_inflight;
    bit          m_out_valid;
    logic [15:0] m_out_data;
    logic [15:0] m_out_pc;
    int unsigned m_count;

    task automatic model_reset();
        m_pc        = 0;
        m_booted    = 0;
        m_inflight  = 0;
        m_out_valid = 0;
        m_out_data  = '0;
        m_out_pc    = '0;
        m_count     = 0;
    endtask

    task automatic model_step();
        if (m_out_valid && instr_ready) m_count++;
        if (!m_booted) begin
            m_booted = 1;
        end else if (redirect_valid) begin
            m_pc        = int'(redirect_addr);
            m_inflight  = 0;
            m_out_valid = 0;
        end else if (m_inflight) begin
            m_out_valid = 1;
            m_out_data  = bram_word(16'(m_pc));
            m_out_pc    = 16'(m_pc);
            m_pc        = (m_pc + 1) % 65536;
            m_inflight  = 0;
        end else if (m_out_valid) begin
            if (instr_ready) m_out_valid = 0;
        end else if (!stall) begin
            m_inflight = 1;
        end
    endtask

    // One clock cycle: drive at negedge, compare, advance model, wait posedge.
    task automatic cycle(input bit s, input bit rv, input logic [15:0] ra,
                         input bit rdy);
        bit exp_en;
        @(negedge clk);
        stall          = s;
        redirect_valid = rv;
        redirect_addr  = ra;
        instr_ready    = rdy;
        #1;
        exp_en = m_booted && !m_inflight && !m_out_valid && !s && !rv;
        check("mem_en", 32'(mem_en), 32'(exp_en));
        check("mem_addr", 32'(mem_addr), 32'(m_pc));
        check("instr_valid", 32'(instr_valid), 32'(m_out_valid));
        check("instr", 32'(instr), 32'(m_out_data));
        check("instr_pc", 32'(instr_pc), 32'(m_out_pc));
`ifdef FETCH_COUNT_EN
        check("fetch_count", fetch_count, m_count);
`endif
        model_step();
        @(posedge clk);
    endtask

    task automatic async_reset(input int offs);
        @(negedge clk);
        #(offs);
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
        check("arst_en", 32'(mem_en), 32'd0);
`ifdef FETCH_COUNT_EN
        check("arst_count", fetch_count, 32'd0);
`endif
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_en", 32'(mem_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_instr", 32'(instr), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;

        // Basic fetch of BRAM[0].
        cycle(0, 0, 16'h0, 1);
        cycle(0, 0, 16'h0, 1);
        cycle(0, 0, 16'h0, 0);
        #1;
        check("t1_valid", 32'(instr_valid), 32'd1);
        check("t1_instr", 32'(instr), 32'h1234);
        check("t1_instr_pc", 32'(instr_pc), 32'd0);
        check("t1_next_addr", 32'(mem_addr), 32'd1);

        // Decoder back-pressure for 5 cycles.
        repeat (5) cycle(0, 0, 16'h0, 0);
        cycle(0, 0, 16'h0, 1);
        #1;
        check("t2_addr", 32'(mem_addr), 32'd1);
        check("t2_valid", 32'(instr_valid), 32'd0);

        // Redirect during the read wait discards that read.
        cycle(0, 0, 16'h0, 0);
        cycle(0, 1, 16'h0040, 0);
        #1;
        check("t3_valid", 32'(instr_valid), 32'd0);
        check("t3_addr", 32'(mem_addr), 32'h40);
        check("t3_instr_kept", 32'(instr), 32'h1234);
        cycle(0, 0, 16'h0, 0);
        cycle(0, 0, 16'h0, 0);
        #1;
        check("t3_instr_pc", 32'(instr_pc), 32'h40);
        check("t3_instr", 32'(instr), 32'(bram_word(16'h40)));
        cycle(0, 0, 16'h0, 1);

        // PC wrap at the top of the address space.
        cycle(0, 1, 16'hFFFF, 0);
        cycle(0, 0, 16'h0, 0);
        cycle(0, 0, 16'h0, 0);
        #1;
        check("t4_instr_pc", 32'(instr_pc), 32'hFFFF);
        check("t4_wrap_addr", 32'(mem_addr), 32'd0);
        cycle(0, 0, 16'h0, 1);

        // Stall holds issue.
        repeat (4) cycle(1, 0, 16'h0, 0);
        #1;
        check("t5_addr", 32'(mem_addr), 32'd0);
        cycle(0, 0, 16'h0, 0);
        cycle(0, 0, 16'h0, 0);
        cycle(0, 0, 16'h0, 1);
        cycle(0, 0, 16'h0, 0);
        cycle(0, 0, 16'h0, 0);
        cycle(0, 0, 16'h0, 0);
        #1;
        check("t6_valid", 32'(instr_valid), 32'd1);
`ifdef FETCH_COUNT_EN
        check("t6_count", fetch_count, 32'd4);
`endif
        // Asynchronous reset in the middle of a hold.
        async_reset(3);

        // Randomized traffic, with one more async reset midway.
        for (int i = 0; i < 3000; i++) begin
            bit          s;
            bit          rv;
            bit          rdy;
            logic [15:0] ra;
            if (i == 1500) async_reset(2);
            s   = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 11) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0)
                ra = 16'hFFFF - 16'($urandom_range(0, 2));
            else
                ra = 16'($urandom);
            cycle(s, rv, ra, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
